// File: rtl/frame_mem_arbiter.sv
// Single-port arbiter for the 4-bit reference-frame RAM: A has fixed priority, B is forced after STARVE_MAX A grants.
// Define FRAME_CLEAR_EN to build the full-frame clear sequencer (CLEAR state plus clear address walk).
module frame_mem_arbiter (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iAReq,
  input  logic        iAWe,
  input  logic [14:0] iAAddr,
  input  logic [3:0]  iAData,
  output logic        oAGrant,
  output logic [3:0]  oAData,
  output logic        oAValid,
  input  logic        iBReq,
  input  logic [14:0] iBAddr,
  output logic        oBGrant,
  output logic [3:0]  oBData,
  output logic        oBValid,
  output logic [14:0] oMemAddr,
  output logic        oMemWe,
  output logic [3:0]  oMemData,
  input  logic [3:0]  iMemData,
  output logic        oAddrErr,
  input  logic        iClearStart,
  output logic        oClearBusy,
  output logic        oClearDone,
  output logic        oDbgState
);

  localparam logic [14:0] FRAME_END  = 15'h57C0;
  localparam logic [3:0]  STARVE_MAX = 4'd8;

  typedef enum logic {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;

  typedef struct packed {
    logic vld_rd;
    logic is_b;
    logic in_range;
  } tag_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_starve;
  logic [14:0] r_mem_addr;
  logic        r_mem_we;
  logic [3:0]  r_mem_data;
  tag_t        r_tag1;
  tag_t        r_tag2;
  logic [3:0]  r_a_data;
  logic        r_a_valid;
  logic [3:0]  r_b_data;
  logic        r_b_valid;
  logic        r_addr_err;
  logic        r_clear_done;

  logic        w_clear_go;
  logic        w_a_gnt;
  logic        w_b_gnt;
  logic        w_force_b;
  logic [14:0] w_sel_addr;
  logic        w_in_range;

`ifdef FRAME_CLEAR_EN
  assign w_clear_go = (r_state == ST_ARB) && iClearStart;
`else
  logic w_unused_clear;
  assign w_unused_clear = iClearStart;
  assign w_clear_go     = 1'b0;
`endif

  assign w_force_b  = (r_starve == STARVE_MAX);
  assign w_sel_addr = w_b_gnt ? iBAddr : iAAddr;
  assign w_in_range = (w_sel_addr < FRAME_END);

  // Handshake: a requester holds req/address until its grant is seen in the same cycle;
  // a request still high after the grant cycle is a new access. Valid pulses last one cycle.
  always_comb begin
    w_next  = r_state;
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (w_clear_go) begin
          w_next = ST_CLEAR;
        end else begin
          w_a_gnt = iAReq && !(iBReq && w_force_b);
          w_b_gnt = iBReq && (!iAReq || w_force_b);
        end
      end
      ST_CLEAR: begin
        if (r_mem_addr == FRAME_END - 15'd1) w_next = ST_ARB;
      end
      default: w_next = ST_ARB;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) r_state <= ST_ARB;
    else        r_state <= w_next;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_starve     <= 4'd0;
      r_mem_addr   <= 15'd0;
      r_mem_we     <= 1'b0;
      r_mem_data   <= 4'h0;
      r_tag1       <= '0;
      r_tag2       <= '0;
      r_a_data     <= 4'h0;
      r_a_valid    <= 1'b0;
      r_b_data     <= 4'h0;
      r_b_valid    <= 1'b0;
      r_addr_err   <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      if (!iBReq || w_b_gnt)                        r_starve <= 4'd0;
      else if (w_a_gnt && (r_starve != STARVE_MAX)) r_starve <= r_starve + 4'd1;

      // The clear walk reuses the RAM address register as its counter.
      r_mem_we <= 1'b0;
      if (w_clear_go) begin
        r_mem_addr <= 15'd0;
        r_mem_we   <= 1'b1;
        r_mem_data <= 4'h0;
      end else if (r_state == ST_CLEAR) begin
        if (w_next == ST_CLEAR) begin
          r_mem_addr <= r_mem_addr + 15'd1;
          r_mem_we   <= 1'b1;
          r_mem_data <= 4'h0;
        end
      end else if (w_a_gnt || w_b_gnt) begin
        r_mem_addr <= w_sel_addr;
        r_mem_we   <= w_a_gnt && iAWe && w_in_range;
        r_mem_data <= w_a_gnt ? iAData : 4'h0;
      end

      r_tag1.vld_rd   <= (w_a_gnt && !iAWe) || w_b_gnt;
      r_tag1.is_b     <= w_b_gnt;
      r_tag1.in_range <= w_in_range;
      r_tag2          <= r_tag1;

      r_a_valid <= r_tag2.vld_rd && !r_tag2.is_b;
      r_b_valid <= r_tag2.vld_rd && r_tag2.is_b;
      if (r_tag2.vld_rd && !r_tag2.is_b) r_a_data <= r_tag2.in_range ? iMemData : 4'h0;
      if (r_tag2.vld_rd && r_tag2.is_b)  r_b_data <= r_tag2.in_range ? iMemData : 4'h0;

      r_addr_err   <= r_addr_err | ((w_a_gnt || w_b_gnt) && !w_in_range);
      r_clear_done <= (r_state == ST_CLEAR) && (w_next == ST_ARB);
    end
  end

  assign oAGrant    = w_a_gnt;
  assign oBGrant    = w_b_gnt;
  assign oAData     = r_a_data;
  assign oAValid    = r_a_valid;
  assign oBData     = r_b_data;
  assign oBValid    = r_b_valid;
  assign oMemAddr   = r_mem_addr;
  assign oMemWe     = r_mem_we;
  assign oMemData   = r_mem_data;
  assign oAddrErr   = r_addr_err;
  assign oClearBusy = (r_state == ST_CLEAR);
  assign oClearDone = r_clear_done;
  assign oDbgState  = r_state;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Bench for frame_mem_arbiter: RAM model, reference model with scoreboard queues, directed and random phases.
module tb_frame_mem_arbiter;

  localparam int FE     = 'h57C0;
  localparam int STARVE = 8;

  logic        clk;
  logic        iReset;
  logic        iAReq, iAWe;
  logic [14:0] iAAddr;
  logic [3:0]  iAData;
  logic        oAGrant, oAValid;
  logic [3:0]  oAData;
  logic        iBReq;
  logic [14:0] iBAddr;
  logic        oBGrant, oBValid;
  logic [3:0]  oBData;
  logic [14:0] oMemAddr;
  logic        oMemWe;
  logic [3:0]  oMemData;
  logic [3:0]  iMemData;
  logic        oAddrErr;
  logic        iClearStart;
  logic        oClearBusy, oClearDone;
  logic        oDbgState;

  frame_mem_arbiter dut (
    .iClock(clk), .iReset(iReset),
    .iAReq(iAReq), .iAWe(iAWe), .iAAddr(iAAddr), .iAData(iAData),
    .oAGrant(oAGrant), .oAData(oAData), .oAValid(oAValid),
    .iBReq(iBReq), .iBAddr(iBAddr),
    .oBGrant(oBGrant), .oBData(oBData), .oBValid(oBValid),
    .oMemAddr(oMemAddr), .oMemWe(oMemWe), .oMemData(oMemData), .iMemData(iMemData),
    .oAddrErr(oAddrErr), .iClearStart(iClearStart),
    .oClearBusy(oClearBusy), .oClearDone(oClearDone), .oDbgState(oDbgState)
  );

  // ---------------- clock / reset / RAM ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] ram [0:32767];
  always @(posedge clk) begin
    if (oMemWe) ram[oMemAddr] <= oMemData;
    iMemData <= ram[oMemAddr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [3:0] a_exp_q[$];
  int         a_due_q[$];
  logic [3:0] b_exp_q[$];
  int         b_due_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0]  ref_mem [0:32767];
  bit          m_en = 1'b1;
  int          m_starve = 0;
  logic        m_err = 1'b0;
  logic        m_we = 1'b0;
  logic [14:0] m_addr = '0;
  logic [3:0]  m_data = '0;
  logic        m_a_gnt = 1'b0;
  logic        m_b_gnt = 1'b0;

  always @(negedge clk) begin
    logic ga, gb, clr, a_in, b_in;
    if (iReset) begin
      a_exp_q.delete(); a_due_q.delete();
      b_exp_q.delete(); b_due_q.delete();
      m_starve = 0; m_err = 1'b0; m_we = 1'b0;
      m_a_gnt = 1'b0; m_b_gnt = 1'b0;
    end else if (m_en) begin
      check("mem_we", oMemWe, m_we);
      if (m_we) begin
        check("mem_addr", oMemAddr, m_addr);
        check("mem_data", oMemData, m_data);
      end
      check("addr_err", oAddrErr, m_err);
`ifdef FRAME_CLEAR_EN
      clr = iClearStart;
`else
      clr = 1'b0;
`endif
      ga = !clr && iAReq && !(iBReq && m_starve == STARVE);
      gb = !clr && iBReq && (!iAReq || m_starve == STARVE);
      check("a_grant", oAGrant, ga);
      check("b_grant", oBGrant, gb);
      a_in = (int'(iAAddr) < FE);
      b_in = (int'(iBAddr) < FE);
      m_we = ga && iAWe && a_in;
      m_addr = iAAddr;
      m_data = iAData;
      if (m_we) ref_mem[iAAddr] = iAData;
      if (ga && !iAWe) begin
        a_exp_q.push_back(a_in ? ref_mem[iAAddr] : 4'h0);
        a_due_q.push_back(cyc + 3);
      end
      if (gb) begin
        b_exp_q.push_back(b_in ? ref_mem[iBAddr] : 4'h0);
        b_due_q.push_back(cyc + 3);
      end
      if ((ga && !a_in) || (gb && !b_in)) m_err = 1'b1;
      if (!iBReq || gb) m_starve = 0;
      else if (ga && m_starve < STARVE) m_starve++;
      m_a_gnt = ga;
      m_b_gnt = gb;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!iReset) begin
      if (a_due_q.size() > 0 && a_due_q[0] == cyc) begin
        check("a_valid", oAValid, 1);
        check("a_data", oAData, a_exp_q[0]);
        void'(a_due_q.pop_front()); void'(a_exp_q.pop_front());
      end else begin
        check("a_valid_idle", oAValid, 0);
      end
      if (b_due_q.size() > 0 && b_due_q[0] == cyc) begin
        check("b_valid", oBValid, 1);
        check("b_data", oBData, b_exp_q[0]);
        void'(b_due_q.pop_front()); void'(b_exp_q.pop_front());
      end else begin
        check("b_valid_idle", oBValid, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input logic is_b);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (is_b ? m_b_gnt : m_a_gnt) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_vec++; n_err++;
    $display("FAIL grant_timeout: requester %0d got no grant, required one within 40 cycles", is_b);
    @(posedge clk); #1;
  endtask

  task automatic a_issue(input logic we, input logic [14:0] addr, input logic [3:0] data);
    iAReq = 1'b1; iAWe = we; iAAddr = addr; iAData = data;
    wait_grant(1'b0);
    iAReq = 1'b0;
  endtask

  task automatic b_issue(input logic [14:0] addr);
    iBReq = 1'b1; iBAddr = addr;
    wait_grant(1'b1);
    iBReq = 1'b0;
  endtask

  function automatic logic [14:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 15'h7FFF;
    if (r == 1) return 15'(FE + $urandom_range(0, 50));
    if (r == 2) return 15'(FE - 1);
    return 15'($urandom_range(0, 15));
  endfunction

  task automatic run_random(input int cycles, input bit a_all, input bit b_all);
    for (int c = 0; c < cycles; c++) begin
      if (!iAReq || m_a_gnt) begin
        if (a_all || $urandom_range(0, 2) != 0) begin
          iAReq = 1'b1; iAWe = 1'($urandom_range(0, 1));
          iAAddr = rand_addr(); iAData = 4'($urandom_range(0, 15));
        end else iAReq = 1'b0;
      end
      if (!iBReq || m_b_gnt) begin
        if (b_all || $urandom_range(0, 2) == 0) begin
          iBReq = 1'b1; iBAddr = rand_addr();
        end else iBReq = 1'b0;
      end
      @(posedge clk); #1;
    end
    iAReq = 1'b0; iBReq = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int busy, bad;
    iReset = 1'b1; iAReq = 1'b0; iAWe = 1'b0; iAAddr = '0; iAData = '0;
    iBReq = 1'b0; iBAddr = '0; iClearStart = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_grant", oAGrant, 0);   check("rst_b_grant", oBGrant, 0);
    check("rst_a_valid", oAValid, 0);   check("rst_a_data", oAData, 0);
    check("rst_b_valid", oBValid, 0);   check("rst_b_data", oBData, 0);
    check("rst_mem_addr", oMemAddr, 0); check("rst_mem_we", oMemWe, 0);
    check("rst_mem_data", oMemData, 0); check("rst_addr_err", oAddrErr, 0);
    check("rst_clr_busy", oClearBusy, 0); check("rst_clr_done", oClearDone, 0);
    @(posedge clk); #1;
    iReset = 1'b0;

    // A write then read
    a_issue(1'b1, 15'h0010, 4'h9);
    a_issue(1'b0, 15'h0010, 4'h0);
    idle(6);

    // fill a small window plus the last legal word
    for (int i = 0; i < 16; i++) a_issue(1'b1, 15'(i), 4'($urandom_range(0, 15)));
    a_issue(1'b1, 15'(FE - 1), 4'hC);
    idle(4);

    // pipelined B reads of 0,1,2
    iBReq = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iBAddr = 15'(k);
      wait_grant(1'b1);
    end
    iBReq = 1'b0;
    idle(6);

    // out of range
    a_issue(1'b1, 15'h57C0, 4'h6);
    @(negedge clk);
    check("addr_err_set", oAddrErr, 1);
    @(posedge clk); #1;
    b_issue(15'h7FFF);
    idle(6);

    // starvation bound then mixed random traffic
    run_random(45, 1'b1, 1'b1);
    idle(6);
    run_random(400, 1'b0, 1'b0);
    idle(6);

`ifdef FRAME_CLEAR_EN
    for (int i = 0; i < 4; i++) a_issue(1'b1, 15'(i), 4'hF);
    idle(4);
    m_en = 1'b0;
    iClearStart = 1'b1; iAReq = 1'b1; iAWe = 1'b1; iAAddr = 15'd5; iAData = 4'hF;
    @(negedge clk);
    check("clr_start_no_grant", {oAGrant, oBGrant}, 0);
    @(posedge clk); #1;
    iClearStart = 1'b0;
    busy = 0; bad = 0;
    while (busy < FE + 20) begin
      @(negedge clk);
      if (!oClearBusy) break;
      busy++;
      if (oAGrant || oBGrant || oClearDone || !oMemWe || oMemData != 4'h0 ||
          oMemAddr != 15'(busy - 1)) bad++;
      if (oMemAddr == 15'(FE - 1)) break;
    end
    check("clr_busy_cycles", busy, FE);
    check("clr_bad_cycles", bad, 0);
    @(posedge clk); #1;
    for (int i = 0; i < FE; i++) ref_mem[i] = 4'h0;
    m_we = 1'b0; m_a_gnt = 1'b0; m_b_gnt = 1'b0;
    m_en = 1'b1;
    @(negedge clk);
    check("clr_done_pulse", oClearDone, 1);
    check("clr_busy_end", oClearBusy, 0);
    @(posedge clk); #1;
    iAReq = 1'b0;
    @(negedge clk);
    check("clr_done_width", oClearDone, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) a_issue(1'b0, 15'(i), 4'h0);
    a_issue(1'b0, 15'd5, 4'h0);
    idle(6);
`else
    iClearStart = 1'b1;
    a_issue(1'b1, 15'd5, 4'hF);
    iClearStart = 1'b0;
    busy = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (oClearBusy || oClearDone) busy++;
    end
    check("noclr_busy_cycles", busy, 0);
    @(posedge clk); #1;
    a_issue(1'b0, 15'd5, 4'h0);
    idle(6);
`endif

    // reset in the cycle after a read grant
    iBReq = 1'b1; iBAddr = 15'd1;
    wait_grant(1'b1);
    iBReq = 1'b0; iReset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mrst_a_valid", oAValid, 0);  check("mrst_b_valid", oBValid, 0);
    check("mrst_b_data", oBData, 0);    check("mrst_mem_we", oMemWe, 0);
    check("mrst_mem_addr", oMemAddr, 0); check("mrst_addr_err", oAddrErr, 0);
    @(posedge clk); #1;
    iReset = 1'b0;
    idle(8);

    check("queues_drained", a_exp_q.size() + b_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
